// File: rtl/dma_addr_datapath.sv
// dma_addr_datapath: register and counter datapath of the DMA address generator.
// Holds the control register (CR), address register (AR), word register (WR),
// address counter (AC) and word counter (WC), and is driven by the decoder strobes.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   PLCR, PLAR, PLWR           load CR (D_IN[2:0]), AR, WR from D_IN
//   SELA, PLAC, ENA, INCA, DECA        address counter source / load / count controls
//   SELW, PLWC, RESW, ENW, INCW, DECW  word counter source / load / clear / count controls
//   SELDATA, OEDATA            read-back select and output enable
//   CEN                        external count enable qualifying ENA and ENW
//   D_IN                       data bus input
//   A                          memory address (address counter)
//   D_OUT, D_OE                read-back data and valid
//   DONE                       transfer complete, selected by CR[1:0]
//   CR_Q                       control register, fed back to the decoder
module dma_addr_datapath #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PLCR,
    input  logic             PLAR,
    input  logic             PLWR,
    input  logic             SELA,
    input  logic             SELW,
    input  logic             PLAC,
    input  logic             ENA,
    input  logic             INCA,
    input  logic             DECA,
    input  logic             PLWC,
    input  logic             RESW,
    input  logic             ENW,
    input  logic             INCW,
    input  logic             DECW,
    input  logic [1:0]       SELDATA,
    input  logic             OEDATA,
    input  logic             CEN,
    input  logic [WIDTH-1:0] D_IN,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] D_OUT,
    output logic             D_OE,
    output logic             DONE,
    output logic [2:0]       CR_Q
);

    localparam logic [WIDTH-1:0] OneW = WIDTH'(1);

    logic [2:0]       cr_q, cr_d;
    logic [WIDTH-1:0] ar_q, ar_d;
    logic [WIDTH-1:0] wr_q, wr_d;
    logic [WIDTH-1:0] ac_q, ac_d;
    logic [WIDTH-1:0] wc_q, wc_d;

    // Count only when exactly one direction is asserted; both or neither holds.
    logic ac_inc, ac_dec, wc_inc, wc_dec;
    assign ac_inc = ENA && CEN && INCA && !DECA;
    assign ac_dec = ENA && CEN && DECA && !INCA;
    assign wc_inc = ENW && CEN && INCW && !DECW;
    assign wc_dec = ENW && CEN && DECW && !INCW;

    // Counter loads from AR/WR read the registered (pre-edge) value.
    always_comb begin
        cr_d = cr_q;
        ar_d = ar_q;
        wr_d = wr_q;
        ac_d = ac_q;
        wc_d = wc_q;

        if (PLCR) cr_d = D_IN[2:0];
        if (PLAR) ar_d = D_IN;
        if (PLWR) wr_d = D_IN;

        if (PLAC)        ac_d = SELA ? ar_q : D_IN;
        else if (ac_inc) ac_d = ac_q + OneW;
        else if (ac_dec) ac_d = ac_q - OneW;

        if (RESW)        wc_d = '0;
        else if (PLWC)   wc_d = SELW ? wr_q : D_IN;
        else if (wc_inc) wc_d = wc_q + OneW;
        else if (wc_dec) wc_d = wc_q - OneW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr_q <= '0;
            ar_q <= '0;
            wr_q <= '0;
            ac_q <= '0;
            wc_q <= '0;
        end else begin
            cr_q <= cr_d;
            ar_q <= ar_d;
            wr_q <= wr_d;
            ac_q <= ac_d;
            wc_q <= wc_d;
        end
    end

    always_comb begin
        DONE = 1'b0;
        unique case (cr_q[1:0])
            2'b00: DONE = (wc_q == OneW);
            2'b01: DONE = (wc_q == wr_q);
            2'b10: DONE = (ac_q == wr_q);
            2'b11: DONE = (wc_q == '0);
            default: DONE = 1'b0;
        endcase
    end

    always_comb begin
        D_OUT = '0;
        if (OEDATA) begin
            case (SELDATA)
                2'b00:   D_OUT = ac_q;
                2'b01:   D_OUT = wc_q;
                default: D_OUT = {{(WIDTH-3){1'b1}}, cr_q};
            endcase
        end
    end

    assign A    = ac_q;
    assign D_OE = OEDATA;
    assign CR_Q = cr_q;

endmodule

// File: tb/tb_dma_addr_datapath.sv
module tb_dma_addr_datapath;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         PLCR, PLAR, PLWR, SELA, SELW, PLAC, ENA, INCA, DECA;
    logic         PLWC, RESW, ENW, INCW, DECW, OEDATA, CEN;
    logic [1:0]   SELDATA;
    logic [W-1:0] D_IN;
    logic [W-1:0] A, D_OUT;
    logic         D_OE, DONE;
    logic [2:0]   CR_Q;

    int checks   = 0;
    int failures = 0;

    // Reference state, plain integers modulo 2^W.
    int m_cr, m_ar, m_wr, m_ac, m_wc;

    always #5 clk = ~clk;

    dma_addr_datapath #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .PLCR(PLCR), .PLAR(PLAR), .PLWR(PLWR),
        .SELA(SELA), .SELW(SELW),
        .PLAC(PLAC), .ENA(ENA), .INCA(INCA), .DECA(DECA),
        .PLWC(PLWC), .RESW(RESW), .ENW(ENW), .INCW(INCW), .DECW(DECW),
        .SELDATA(SELDATA), .OEDATA(OEDATA), .CEN(CEN), .D_IN(D_IN),
        .A(A), .D_OUT(D_OUT), .D_OE(D_OE), .DONE(DONE), .CR_Q(CR_Q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_in();
        {PLCR, PLAR, PLWR, SELA, SELW, PLAC, ENA, INCA, DECA} = '0;
        {PLWC, RESW, ENW, INCW, DECW, OEDATA, CEN} = '0;
        SELDATA = 2'b00;
        D_IN    = '0;
    endtask

    task automatic model_reset();
        m_cr = 0; m_ar = 0; m_wr = 0; m_ac = 0; m_wc = 0;
    endtask

    // Apply one clock edge of the rules to the model, using pre-edge values.
    task automatic model_step();
        int d, ac_n, wc_n;
        d    = int'(D_IN);
        ac_n = m_ac;
        wc_n = m_wc;
        if (PLAC)
            ac_n = SELA ? m_ar : d;
        else if (ENA && CEN && (INCA != DECA))
            ac_n = INCA ? (m_ac + 1) % (MASK + 1) : (m_ac + MASK) % (MASK + 1);
        if (RESW)
            wc_n = 0;
        else if (PLWC)
            wc_n = SELW ? m_wr : d;
        else if (ENW && CEN && (INCW != DECW))
            wc_n = INCW ? (m_wc + 1) % (MASK + 1) : (m_wc + MASK) % (MASK + 1);
        if (PLCR) m_cr = d % 8;
        if (PLAR) m_ar = d;
        if (PLWR) m_wr = d;
        m_ac = ac_n;
        m_wc = wc_n;
    endtask

    function automatic int exp_done();
        case (m_cr % 4)
            0:       return int'(m_wc == 1);
            1:       return int'(m_wc == m_wr);
            2:       return int'(m_ac == m_wr);
            default: return int'(m_wc == 0);
        endcase
    endfunction

    function automatic int exp_dout();
        if (!OEDATA) return 0;
        if (SELDATA == 2'b00) return m_ac;
        if (SELDATA == 2'b01) return m_wc;
        return (MASK - 7) + m_cr;
    endfunction

    task automatic check_all();
        check("A",     32'(A),     32'(m_ac));
        check("CR_Q",  32'(CR_Q),  32'(m_cr));
        check("DONE",  32'(DONE),  32'(exp_done()));
        check("D_OUT", 32'(D_OUT), 32'(exp_dout()));
        check("D_OE",  32'(D_OE),  32'(OEDATA));
    endtask

    // One rising edge with the currently driven strobes, then compare.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        clear_in();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        OEDATA = 1'b1;
        #1;
        check("rst_A", 32'(A), 0);
        check("rst_DONE", 32'(DONE), 0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Control register load and read-back of {ones, CR}.
        clear_in();
        PLCR = 1'b1; D_IN = 8'h05;
        cyc();
        check("cr_load", 32'(CR_Q), 32'h5);
        clear_in();
        OEDATA = 1'b1; SELDATA = 2'b10;
        #1;
        check("cr_readback", 32'(D_OUT), 32'hFD);

        // Address load from AR and increment through the wrap.
        clear_in();
        PLAR = 1'b1; D_IN = 8'hFE;
        cyc();
        clear_in();
        PLAC = 1'b1; SELA = 1'b1; D_IN = 8'h33;
        cyc();
        check("ac_load_ar", 32'(A), 32'hFE);
        clear_in();
        ENA = 1'b1; INCA = 1'b1; CEN = 1'b1;
        cyc(); check("ac_inc_ff", 32'(A), 32'hFF);
        cyc(); check("ac_wrap_00", 32'(A), 32'h00);
        cyc(); check("ac_inc_01", 32'(A), 32'h01);

        // Mode 00: DONE exactly while WC==1.
        clear_in();
        PLCR = 1'b1; D_IN = 8'h00;
        cyc();
        clear_in();
        PLWC = 1'b1; SELW = 1'b0; D_IN = 8'h03; OEDATA = 1'b1; SELDATA = 2'b01;
        cyc();
        check("wc_load3", 32'(D_OUT), 3);
        check("m00_done_wc3", 32'(DONE), 0);
        PLWC = 1'b0; ENW = 1'b1; DECW = 1'b1; CEN = 1'b1;
        cyc(); check("wc_dec2", 32'(D_OUT), 2); check("m00_done_wc2", 32'(DONE), 0);
        cyc(); check("wc_dec1", 32'(D_OUT), 1); check("m00_done_wc1", 32'(DONE), 1);
        cyc(); check("wc_dec0", 32'(D_OUT), 0); check("m00_done_wc0", 32'(DONE), 0);

        // Mode 01: WC==WR.
        clear_in();
        PLCR = 1'b1; PLWR = 1'b1; RESW = 1'b1; D_IN = 8'h01;
        cyc();
        clear_in();
        PLWR = 1'b1; D_IN = 8'h04;
        cyc();
        clear_in();
        ENW = 1'b1; INCW = 1'b1; CEN = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            check("m01_done", 32'(DONE), 32'(i == 4));
        end

        // Mode 10: AC==WR.
        clear_in();
        PLCR = 1'b1; D_IN = 8'h02;
        cyc();
        clear_in();
        PLWR = 1'b1; D_IN = 8'h10;
        cyc();
        clear_in();
        PLAC = 1'b1; SELA = 1'b0; D_IN = 8'h0E;
        cyc();
        check("m10_done_0e", 32'(DONE), 0);
        clear_in();
        ENA = 1'b1; INCA = 1'b1; CEN = 1'b1;
        cyc(); check("m10_done_0f", 32'(DONE), 0);
        cyc(); check("m10_a_10", 32'(A), 32'h10); check("m10_done_10", 32'(DONE), 1);

        // Priority and gating.
        clear_in();
        RESW = 1'b1; PLWC = 1'b1; ENW = 1'b1; INCW = 1'b1; CEN = 1'b1; D_IN = 8'h07;
        OEDATA = 1'b1; SELDATA = 2'b01;
        cyc();
        check("resw_wins", 32'(D_OUT), 0);
        clear_in();
        PLAC = 1'b1; ENA = 1'b1; INCA = 1'b1; CEN = 1'b1; D_IN = 8'h40;
        cyc();
        check("plac_wins", 32'(A), 32'h40);
        clear_in();
        ENA = 1'b1; INCA = 1'b1; CEN = 1'b0;
        repeat (5) cyc();
        check("cen_hold", 32'(A), 32'h40);
        CEN = 1'b1; DECA = 1'b1;
        cyc();
        check("incdec_hold", 32'(A), 32'h40);

        // Randomized traffic against the model; small D_IN values hit DONE often.
        for (int n = 0; n < 400; n++) begin
            PLCR = ($urandom_range(0, 7) == 0);
            PLAR = ($urandom_range(0, 5) == 0);
            PLWR = ($urandom_range(0, 5) == 0);
            SELA = 1'($urandom);
            SELW = 1'($urandom);
            PLAC = ($urandom_range(0, 7) == 0);
            ENA  = ($urandom_range(0, 3) != 0);
            INCA = 1'($urandom);
            DECA = 1'($urandom);
            PLWC = ($urandom_range(0, 7) == 0);
            RESW = ($urandom_range(0, 15) == 0);
            ENW  = ($urandom_range(0, 3) != 0);
            INCW = 1'($urandom);
            DECW = 1'($urandom);
            CEN  = ($urandom_range(0, 3) != 0);
            SELDATA = 2'($urandom);
            OEDATA  = 1'($urandom);
            D_IN = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 5)) : W'($urandom);
            cyc();
        end

        // Asynchronous reset in the middle of counting, away from the clock edge.
        clear_in();
        PLAC = 1'b1; D_IN = 8'h80;
        PLWC = 1'b1;
        cyc();
        clear_in();
        ENA = 1'b1; INCA = 1'b1; ENW = 1'b1; INCW = 1'b1; CEN = 1'b1;
        OEDATA = 1'b1; SELDATA = 2'b00;
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_A", 32'(A), 0);
        check("async_rst_CR", 32'(CR_Q), 0);
        check("async_rst_DOUT", 32'(D_OUT), 0);
        SELDATA = 2'b01;
        #1;
        check("async_rst_WC", 32'(D_OUT), 0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        clear_in();
        PLCR = 1'b1; D_IN = 8'h03;
        cyc();
        check("post_rst_cr", 32'(CR_Q), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_addr_datapath.md
# dma_addr_datapath

Register and counter datapath of the DMA address generator. It consumes the control strobes produced by the instruction decoder, and holds the 3-bit control register, address register, word register, address counter and word counter. It drives the memory address bus, the internal data read-back bus and the transfer-complete flag. It sits directly downstream of the instruction decoder and owns all sequential state of the generator.

## Interface

Parameters:
- WIDTH, 8, width of the address, word and data paths; legal values are 4 to 16.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- PLCR, PLAR, PLWR, input, 1 each: load the control, address and word registers from D_IN.
- SELA, input, 1: address counter load source; 1 selects the address register, 0 selects D_IN.
- SELW, input, 1: word counter load source; 1 selects the word register, 0 selects D_IN.
- PLAC, ENA, INCA, DECA, input, 1 each: address counter load, count enable, increment and decrement.
- PLWC, RESW, ENW, INCW, DECW, input, 1 each: word counter load, reset, count enable, increment and decrement.
- SELDATA, input, 2: read-back select.
- OEDATA, input, 1: read-back output enable.
- CEN, input, 1: external count enable that qualifies ENA and ENW.
- D_IN, input, WIDTH: data bus input.
- A, output, WIDTH: address, equal to the address counter.
- D_OUT, output, WIDTH: read-back data.
- D_OE, output, 1: read-back valid.
- DONE, output, 1: transfer complete.
- CR_Q, output, 3: current control register value, fed back to the decoder as its CR input.

## Operation

- Reset value of every register is 0: CR, AR, WR, AC and WC. While reset is asserted, A=0, CR_Q=0, and DONE=0 because WC=0 is not equal to 1 in mode 00.
- PLCR: CR takes D_IN[2:0]. PLAR: AR takes D_IN. PLWR: WR takes D_IN. All three loads are independent and may occur in the same cycle.
- Address counter AC, priority from highest:
  - PLAC: load AR if SELA=1, else load D_IN.
  - ENA&CEN&INCA: AC+1.
  - ENA&CEN&DECA: AC-1.
  - Otherwise hold.
- If INCA and DECA are both 1, or neither is exactly 1 (including X), AC holds.
- Word counter WC, priority from highest:
  - RESW: 0.
  - PLWC: load WR if SELW=1, else load D_IN.
  - ENW&CEN&INCW: WC+1.
  - ENW&CEN&DECW: WC-1.
  - Otherwise hold, with the same both/neither rule as AC.
- All arithmetic is modulo 2^WIDTH: all-ones +1 gives 0, and 0 -1 gives all-ones. There is no saturation and no carry output.
- Same-edge load and use: loads of AR and WR and a counter load from AR or WR in the same cycle use the pre-edge (old) AR or WR value.
- DONE is combinational from registered state, selected by CR[1:0]:
  - 00: WC==1.
  - 01: WC==WR.
  - 10: AC==WR.
  - 11: WC==0.
- DONE is not sticky. Counting continues past DONE unless the decoder or CEN stops it.
- Read-back D_OUT, selected by SELDATA:
  - 00: AC.
  - 01: WC.
  - 1x: {WIDTH-3 ones, CR}.
- D_OE = OEDATA. D_OUT is driven to all zeros when OEDATA=0.

## Timing

- Every register update is visible on A, CR_Q and D_OUT one cycle after the strobes are sampled, i.e. after the rising edge.
- DONE is valid in the same cycle the counter reaches its terminal value, after the edge, with no extra latency.
- D_OUT and D_OE are purely combinational from SELDATA, OEDATA and registered state, with zero-cycle latency.
- Reset asserted mid-transfer clears all state immediately, without waiting for the clock. The first load after release takes effect on the first rising edge with rst_n=1.
- CEN=0 freezes counting but not loads or RESW.
- CR_Q feedback into the decoder forms no combinational loop: the strobes depend on CR_Q only, and CR_Q is registered.

## Test plan

- Reset and read-back:
  - Assert rst_n=0 mid-count. A, WC, CR_Q and D_OUT(SELDATA=00, OE=1) must all read 0 immediately.
  - After release, PLCR with D_IN=8'h05 gives CR_Q=3'b101.
  - A subsequent read with SELDATA=2'b10 gives D_OUT=8'hFD.
- Address load and increment wrap:
  - PLAR with D_IN=8'hFE, then PLAC with SELA=1, then 3 cycles of ENA=INCA=CEN=1.
  - A must read FE, FF, 00, 01.
- Word count mode 00:
  - CR=000, PLWC with SELW=0 and D_IN=3, then decrement with ENW=DECW=CEN=1.
  - WC must read 3, 2, 1, with DONE=1 exactly in the cycle WC==1. The next decrement gives WC=0 and DONE=0.
- Compare modes:
  - CR=001, WR=4, RESW, then increment. DONE must rise when WC==4.
  - CR=010, WR=8'h10, AC loaded to 8'h0E and incremented. DONE must rise when A==8'h10.
- Priority and gating:
  - Same cycle RESW=1, PLWC=1 and ENW=INCW=1 gives WC=0.
  - PLAC=1 with ENA=INCA=1 loads without incrementing.
  - CEN=0 with ENA=INCA=1 holds AC over 5 cycles.
  - INCA=DECA=1 holds AC.
